pe_sequencer: RTL and testbench
===============================

PE_SEQUENCER -- requirements
Module: pe_sequencer

Interface
REQ-001 Parameter DRAIN_CYC, 3, cycles waited after PE_BIAS for the MAC pipeline to drain.
REQ-002 Parameter ACT_CYC, 23, cycles PE_ACT is held when activation is enabled; held 1 cycle otherwise.
REQ-003 Port clk  input  1  single clock; all state changes on rising edge.
REQ-004 Port rst  input  1  asynchronous, active-low reset.
REQ-005 Port start  input  1  one-cycle pulse; accepted only in S_IDLE.
REQ-006 Port abort  input  1  synchronous abort; return to S_IDLE next cycle.
REQ-007 Port cfg_nwgt  input  12  weight/bias words to load (0 = skip load).
REQ-008 Port cfg_nin  input  5  inputs per neuron pass (must be >=1).
REQ-009 Port cfg_npass  input  8  neuron passes (must be >=1).
REQ-010 Port cfg_act  input  1  enable activation (drives do_act).
REQ-011 Port in_data, in_valid / in_ready  input 32, input 1 / output 1  upstream word stream, valid/ready handshake.
REQ-012 Port pe_state  output  3  PE command (PE_IDLE..PE_ACT_CLR encoding).
REQ-013 Port pe_oe  output  1  PE output enable.
REQ-014 Port pe_data  output  32  word to PE data bus; 32'h0 when not driving.
REQ-015 Port do_act  output  1  activation select to PE.
REQ-016 Port busy, done  output 1, output 1  busy = not S_IDLE; done = one-cycle completion pulse.

Function
REQ-017 cfg_* SHALL be latched on accepted start; later changes ignored until next start.
REQ-018 FSM states: S_IDLE, S_LOAD, S_MA, S_BIAS, S_DRAIN, S_ACT, S_OUT.
REQ-019 S_IDLE->S_LOAD on start (S_MA if cfg_nwgt=0); start while busy SHALL be ignored.
REQ-020 In S_LOAD/S_MA/S_BIAS in_ready=1; a word transfers when in_valid&in_ready; in_ready=0 in all other states.
REQ-021 Transfer cycle: pe_data=in_data registered, pe_state=PE_LOAD/PE_MA/PE_BIAS respectively, one cycle later (latency 1).
REQ-022 Stall (in_valid=0 in a streaming state): next-cycle pe_state=PE_IDLE, pe_data=0; no counter advances.
REQ-023 S_LOAD exits to S_MA after cfg_nwgt transfers; S_MA exits to S_BIAS after cfg_nin transfers; S_BIAS after 1 transfer -> S_DRAIN.
REQ-024 S_DRAIN: pe_state=PE_IDLE for DRAIN_CYC cycles, then S_ACT.
REQ-025 S_ACT: pe_state=PE_ACT for ACT_CYC cycles if cfg_act else 1 cycle; do_act=cfg_act throughout the job.
REQ-026 After S_ACT: pass counter+1; if < cfg_npass -> S_MA, else S_OUT.
REQ-027 S_OUT: pe_state=PE_IDLE, pe_oe=1 for exactly 1 cycle; then S_IDLE with done=1 that same cycle.
REQ-028 Counters: word counter 12 bit, cycle counter 5 bit, pass counter 8 bit; all clear on state entry; no wrap permitted.
REQ-029 abort in any state: next cycle S_IDLE, all outputs at reset values, done SHALL NOT pulse; abort with start same cycle: abort wins.
REQ-030 pe_oe SHALL be 0 outside S_OUT; pe_state SHALL never be PE_MAB, PE_MABO or PE_ACT_CLR.

Reset
REQ-031 rst low asynchronously SHALL force S_IDLE, pe_state=PE_IDLE, pe_oe=0, pe_data=0, do_act=0, in_ready=0, busy=0, done=0, all counters and latched cfg 0.
REQ-032 Reset mid-job SHALL discard the job; no done after release.

Structure
REQ-033 PE command encodings (PE_IDLE=0, PE_LOAD=1, PE_MA=2, PE_MAB=3, PE_MABO=4, PE_BIAS=5, PE_ACT=6, PE_ACT_CLR=7) and FSM state encodings SHALL live in a shared package used by PE and sequencer.
REQ-034 Single module; no sub-module.

Verification
REQ-035 cfg_nwgt=6, nin=2, npass=1, act=0, in_valid always 1 -> pe_state LOAD x6, MA x2, BIAS x1, IDLE x3, ACT x1, pe_oe 1 cycle, done pulse.
REQ-036 cfg_act=1, npass=2 -> two MA/BIAS/DRAIN/ACT rounds, each ACT held 23 cycles, do_act=1, single done.
REQ-037 in_valid low 2 cycles mid-S_MA -> 2 PE_IDLE bubbles, exactly cfg_nin PE_MA words delivered in order (4096.0, 2.0).
REQ-038 abort during S_ACT -> S_IDLE next cycle, pe_oe=0, no done; new start runs normally.
REQ-039 rst low during S_LOAD (async, mid-cycle) -> outputs zero immediately; start while busy ignored.

Source files
------------

// File: rtl/pe_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pe_sequencer_pkg
// Description : Shared PE command and sequencer state encodings, counter
//               widths and small helpers used by the PE and its sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package pe_sequencer_pkg;

  // Command word driven onto the PE command bus
  typedef enum logic [2:0] {
    PE_IDLE    = 3'd0,
    PE_LOAD    = 3'd1,
    PE_MA      = 3'd2,
    PE_MAB     = 3'd3,
    PE_MABO    = 3'd4,
    PE_BIAS    = 3'd5,
    PE_ACT     = 3'd6,
    PE_ACT_CLR = 3'd7
  } pe_cmd_e;

  // Sequencer FSM states
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_MA    = 3'd2,
    S_BIAS  = 3'd3,
    S_DRAIN = 3'd4,
    S_ACT   = 3'd5,
    S_OUT   = 3'd6
  } seq_state_e;

  localparam int unsigned C_DATA_W     = 32;
  localparam int unsigned C_WORD_CNT_W = 12;
  localparam int unsigned C_NIN_W      = 5;
  localparam int unsigned C_CYC_CNT_W  = 5;
  localparam int unsigned C_PASS_CNT_W = 8;

  // Terminal count of a fixed-length phase; a zero length collapses to one cycle
  function automatic logic [C_CYC_CNT_W-1:0] last_cycle(input int unsigned n);
    logic [C_CYC_CNT_W-1:0] v;
    v = (n == 0) ? '0 : C_CYC_CNT_W'(n - 1);
    return v;
  endfunction

endpackage : pe_sequencer_pkg
`default_nettype wire

// File: rtl/pe_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : pe_sequencer
// Description : Sequences a processing element through weight load, MAC
//               passes, bias, pipeline drain, activation and output phases.
//               Streaming words arrive on a valid/ready port and are forwarded
//               to the PE one cycle later together with the matching command.
// Revision    : 1.0 - initial release
// ============================================================================
module pe_sequencer
  import pe_sequencer_pkg::*;
#(
  parameter int unsigned DRAIN_CYC = 3,
  parameter int unsigned ACT_CYC   = 23
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    abort,
  input  logic [C_WORD_CNT_W-1:0] cfg_nwgt,
  input  logic [C_NIN_W-1:0]      cfg_nin,
  input  logic [C_PASS_CNT_W-1:0] cfg_npass,
  input  logic                    cfg_act,
  input  logic [C_DATA_W-1:0]     in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [2:0]              pe_state,
  output logic                    pe_oe,
  output logic [C_DATA_W-1:0]     pe_data,
  output logic                    do_act,
  output logic                    busy,
  output logic                    done
);

  localparam logic [C_CYC_CNT_W-1:0] C_DRAIN_LAST = last_cycle(DRAIN_CYC);
  localparam logic [C_CYC_CNT_W-1:0] C_ACT_LAST   = last_cycle(ACT_CYC);

  // State, counters and latched job configuration
  seq_state_e              r_state,     w_state_d;
  logic [C_WORD_CNT_W-1:0] r_word_cnt,  w_word_cnt_d;
  logic [C_CYC_CNT_W-1:0]  r_cyc_cnt,   w_cyc_cnt_d;
  logic [C_PASS_CNT_W-1:0] r_pass_cnt,  w_pass_cnt_d;
  logic [C_WORD_CNT_W-1:0] r_cfg_nwgt,  w_cfg_nwgt_d;
  logic [C_NIN_W-1:0]      r_cfg_nin,   w_cfg_nin_d;
  logic [C_PASS_CNT_W-1:0] r_cfg_npass, w_cfg_npass_d;
  logic                    r_cfg_act,   w_cfg_act_d;

  // Registered PE-facing outputs
  pe_cmd_e                 r_pe_state,  w_pe_state_d;
  logic [C_DATA_W-1:0]     r_pe_data,   w_pe_data_d;
  logic                    r_pe_oe,     w_pe_oe_d;
  logic                    r_do_act,    w_do_act_d;
  logic                    r_done,      w_done_d;

  logic                    w_in_ready;
  logic                    w_xfer;
  logic [C_WORD_CNT_W-1:0] w_word_inc;
  logic [C_WORD_CNT_W-1:0] w_nin_ext;
  logic [C_CYC_CNT_W-1:0]  w_cyc_inc;
  logic [C_CYC_CNT_W-1:0]  w_act_last;
  logic [C_PASS_CNT_W-1:0] w_pass_inc;

  // Counter increments never wrap: each counter stops at its exit condition
  assign w_word_inc = r_word_cnt + 1'b1;
  assign w_nin_ext  = {{(C_WORD_CNT_W - C_NIN_W){1'b0}}, r_cfg_nin};
  assign w_cyc_inc  = r_cyc_cnt + 1'b1;
  assign w_pass_inc = r_pass_cnt + 1'b1;
  assign w_act_last = r_cfg_act ? C_ACT_LAST : '0;
  assign w_xfer     = w_in_ready & in_valid;

  // Next-state, counter and output decode; abort overrides everything last
  always_comb begin
    w_state_d     = r_state;
    w_word_cnt_d  = r_word_cnt;
    w_cyc_cnt_d   = r_cyc_cnt;
    w_pass_cnt_d  = r_pass_cnt;
    w_cfg_nwgt_d  = r_cfg_nwgt;
    w_cfg_nin_d   = r_cfg_nin;
    w_cfg_npass_d = r_cfg_npass;
    w_cfg_act_d   = r_cfg_act;
    w_pe_state_d  = PE_IDLE;
    w_pe_data_d   = '0;
    w_pe_oe_d     = 1'b0;
    w_done_d      = 1'b0;
    w_do_act_d    = r_cfg_act;
    w_in_ready    = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        w_do_act_d = 1'b0;
        if (start) begin
          w_cfg_nwgt_d  = cfg_nwgt;
          w_cfg_nin_d   = cfg_nin;
          w_cfg_npass_d = cfg_npass;
          w_cfg_act_d   = cfg_act;
          w_do_act_d    = cfg_act;
          w_word_cnt_d  = '0;
          w_cyc_cnt_d   = '0;
          w_pass_cnt_d  = '0;
          // An empty weight set skips straight to the first MAC pass
          w_state_d     = (cfg_nwgt == '0) ? S_MA : S_LOAD;
        end
      end

      S_LOAD: begin
        w_in_ready = 1'b1;
        if (w_xfer) begin
          w_pe_state_d = PE_LOAD;
          w_pe_data_d  = in_data;
          if (w_word_inc >= r_cfg_nwgt) begin
            w_word_cnt_d = '0;
            w_state_d    = S_MA;
          end else begin
            w_word_cnt_d = w_word_inc;
          end
        end
      end

      S_MA: begin
        w_in_ready = 1'b1;
        if (w_xfer) begin
          w_pe_state_d = PE_MA;
          w_pe_data_d  = in_data;
          // ">=" lets a zero input count behave as a single input
          if (w_word_inc >= w_nin_ext) begin
            w_word_cnt_d = '0;
            w_state_d    = S_BIAS;
          end else begin
            w_word_cnt_d = w_word_inc;
          end
        end
      end

      S_BIAS: begin
        w_in_ready = 1'b1;
        if (w_xfer) begin
          w_pe_state_d = PE_BIAS;
          w_pe_data_d  = in_data;
          w_cyc_cnt_d  = '0;
          w_state_d    = S_DRAIN;
        end
      end

      S_DRAIN: begin
        if (r_cyc_cnt >= C_DRAIN_LAST) begin
          w_cyc_cnt_d = '0;
          w_state_d   = S_ACT;
        end else begin
          w_cyc_cnt_d = w_cyc_inc;
        end
      end

      S_ACT: begin
        w_pe_state_d = PE_ACT;
        if (r_cyc_cnt >= w_act_last) begin
          w_cyc_cnt_d  = '0;
          w_pass_cnt_d = w_pass_inc;
          w_word_cnt_d = '0;
          w_state_d    = (w_pass_inc >= r_cfg_npass) ? S_OUT : S_MA;
        end else begin
          w_cyc_cnt_d = w_cyc_inc;
        end
      end

      S_OUT: begin
        // Output enable and done land together in the first idle cycle
        w_pe_oe_d = 1'b1;
        w_done_d  = 1'b1;
        w_state_d = S_IDLE;
      end

      default: begin
        w_do_act_d = 1'b0;
        w_state_d  = S_IDLE;
      end
    endcase

    if (abort) begin
      w_state_d     = S_IDLE;
      w_word_cnt_d  = '0;
      w_cyc_cnt_d   = '0;
      w_pass_cnt_d  = '0;
      w_cfg_nwgt_d  = '0;
      w_cfg_nin_d   = '0;
      w_cfg_npass_d = '0;
      w_cfg_act_d   = 1'b0;
      w_pe_state_d  = PE_IDLE;
      w_pe_data_d   = '0;
      w_pe_oe_d     = 1'b0;
      w_done_d      = 1'b0;
      w_do_act_d    = 1'b0;
    end
  end

  // State, counter, configuration and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_word_cnt  <= '0;
      r_cyc_cnt   <= '0;
      r_pass_cnt  <= '0;
      r_cfg_nwgt  <= '0;
      r_cfg_nin   <= '0;
      r_cfg_npass <= '0;
      r_cfg_act   <= 1'b0;
      r_pe_state  <= PE_IDLE;
      r_pe_data   <= '0;
      r_pe_oe     <= 1'b0;
      r_do_act    <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_word_cnt  <= w_word_cnt_d;
      r_cyc_cnt   <= w_cyc_cnt_d;
      r_pass_cnt  <= w_pass_cnt_d;
      r_cfg_nwgt  <= w_cfg_nwgt_d;
      r_cfg_nin   <= w_cfg_nin_d;
      r_cfg_npass <= w_cfg_npass_d;
      r_cfg_act   <= w_cfg_act_d;
      r_pe_state  <= w_pe_state_d;
      r_pe_data   <= w_pe_data_d;
      r_pe_oe     <= w_pe_oe_d;
      r_do_act    <= w_do_act_d;
      r_done      <= w_done_d;
    end
  end

  assign in_ready = w_in_ready;
  assign pe_state = r_pe_state;
  assign pe_data  = r_pe_data;
  assign pe_oe    = r_pe_oe;
  assign do_act   = r_do_act;
  assign done     = r_done;
  assign busy     = (r_state != S_IDLE);

endmodule : pe_sequencer
`default_nettype wire

// File: tb/tb_pe_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_pe_sequencer
// Description : Self-checking bench for pe_sequencer. A job is modelled as a
//               list of work items (stream words, fixed idle/activation
//               cycles, one output cycle); each clock pops at most one item.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pe_sequencer;

  localparam int DRAIN = 3;
  localparam int ACTN  = 23;
  localparam logic [2:0] K_IDLE = 3'd0, K_LOAD = 3'd1, K_MA = 3'd2,
                         K_BIAS = 3'd5, K_ACT = 3'd6;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0, abort = 1'b0;
  logic [11:0] cfg_nwgt = '0;
  logic [4:0]  cfg_nin = '0;
  logic [7:0]  cfg_npass = '0;
  logic        cfg_act = 1'b0;
  logic [31:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready, pe_oe, do_act, busy, done;
  logic [2:0]  pe_state;
  logic [31:0] pe_data;

  int checks = 0;
  int failures = 0;

  pe_sequencer #(.DRAIN_CYC(DRAIN), .ACT_CYC(ACTN)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .cfg_nwgt(cfg_nwgt), .cfg_nin(cfg_nin), .cfg_npass(cfg_npass), .cfg_act(cfg_act),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .pe_state(pe_state), .pe_oe(pe_oe), .pe_data(pe_data),
    .do_act(do_act), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  wire [39:0] obs = {pe_state, pe_data, pe_oe, done, do_act, in_ready, busy};

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [2:0] cmd;
    logic       stream;
    logic       out;
  } item_t;

  item_t       m_q[$];
  logic [2:0]  m_pe_state = '0;
  logic [31:0] m_pe_data = '0;
  logic        m_oe = 1'b0, m_done = 1'b0, m_do_act = 1'b0, m_job_act = 1'b0;

  function automatic item_t mk(input logic [2:0] c, input logic s, input logic o);
    item_t it;
    it.cmd = c; it.stream = s; it.out = o;
    return it;
  endfunction

  task automatic build_job(input int nwgt, input int nin, input int npass, input bit act);
    for (int i = 0; i < nwgt; i++) m_q.push_back(mk(K_LOAD, 1'b1, 1'b0));
    for (int p = 0; p < npass; p++) begin
      for (int i = 0; i < nin; i++) m_q.push_back(mk(K_MA, 1'b1, 1'b0));
      m_q.push_back(mk(K_BIAS, 1'b1, 1'b0));
      for (int i = 0; i < DRAIN; i++) m_q.push_back(mk(K_IDLE, 1'b0, 1'b0));
      for (int i = 0; i < (act ? ACTN : 1); i++) m_q.push_back(mk(K_ACT, 1'b0, 1'b0));
    end
    m_q.push_back(mk(K_IDLE, 1'b0, 1'b1));
  endtask

  task automatic model_reset();
    m_q.delete();
    m_pe_state = '0; m_pe_data = '0; m_oe = 0; m_done = 0; m_do_act = 0; m_job_act = 0;
  endtask

  // Predicts the registered outputs seen after the coming clock edge
  task automatic step_model(input bit st, input bit ab, input bit v, input logic [31:0] d);
    item_t it;
    m_pe_state = K_IDLE; m_pe_data = '0; m_oe = 0; m_done = 0;
    if (ab) begin
      m_q.delete(); m_do_act = 0; m_job_act = 0;
    end else if (m_q.size() == 0) begin
      m_do_act = 0;
      if (st) begin
        build_job(int'(cfg_nwgt), int'(cfg_nin), int'(cfg_npass), cfg_act);
        m_job_act = cfg_act;
        m_do_act  = cfg_act;
      end
    end else begin
      it = m_q[0];
      m_do_act = m_job_act;
      if (it.out) begin
        m_oe = 1; m_done = 1; void'(m_q.pop_front());
      end else if (it.stream) begin
        if (v) begin m_pe_state = it.cmd; m_pe_data = d; void'(m_q.pop_front()); end
      end else begin
        m_pe_state = it.cmd; void'(m_q.pop_front());
      end
    end
  endtask

  function automatic logic [39:0] exp_vec();
    logic rdy, bsy;
    bsy = (m_q.size() > 0);
    rdy = bsy && m_q[0].stream;
    return {m_pe_state, m_pe_data, m_oe, m_done, m_do_act, rdy, bsy};
  endfunction

  // Drive one cycle of stimulus from a falling edge, return at the next one
  task automatic tick(input bit st, input bit ab, input bit v, input logic [31:0] d);
    start = st; abort = ab; in_valid = v; in_data = d;
    step_model(st, ab, v, d);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
  endtask

  task automatic set_cfg(input int nw, input int ni, input int np, input bit a);
    cfg_nwgt = 12'(nw); cfg_nin = 5'(ni); cfg_npass = 8'(np); cfg_act = a;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (obs !== 40'h0) begin
      failures++; $display("FAIL reset_state got=%h exp=%h", obs, 40'h0);
    end
    rst = 1'b1;
    tick(0, 0, 1, 32'hdead_beef);
    checks++;
    if (obs !== exp_vec()) begin
      failures++; $display("FAIL reset_idle got=%h exp=%h", obs, exp_vec());
    end
  endtask

  task automatic test_basic();
    int n_load = 0, n_ma = 0, n_bias = 0, n_act = 0, n_oe = 0, n_done = 0, g = 0;
    set_cfg(6, 2, 1, 0);
    tick(1, 0, 1, $urandom);
    do begin
      tick(0, 0, 1, $urandom);
      g++;
      checks++;
      if (obs !== exp_vec()) begin
        failures++; $display("FAIL basic cyc=%0d got=%h exp=%h", g, obs, exp_vec());
      end
      n_load += (pe_state == K_LOAD); n_ma  += (pe_state == K_MA);
      n_bias += (pe_state == K_BIAS); n_act += (pe_state == K_ACT);
      n_oe += pe_oe; n_done += done;
    end while (m_q.size() > 0 && g < 500);
    checks++;
    if (g >= 500) begin failures++; $display("FAIL basic_timeout cycles=%0d limit=500", g); end
    checks++; if (n_load != 6) begin failures++; $display("FAIL basic_load got=%0d exp=6", n_load); end
    checks++; if (n_ma != 2)   begin failures++; $display("FAIL basic_ma got=%0d exp=2", n_ma); end
    checks++; if (n_bias != 1) begin failures++; $display("FAIL basic_bias got=%0d exp=1", n_bias); end
    checks++; if (n_act != 1)  begin failures++; $display("FAIL basic_act got=%0d exp=1", n_act); end
    checks++; if (n_oe != 1)   begin failures++; $display("FAIL basic_oe got=%0d exp=1", n_oe); end
    checks++; if (n_done != 1) begin failures++; $display("FAIL basic_done got=%0d exp=1", n_done); end
  endtask

  task automatic test_act_multipass();
    int n_act = 0, n_done = 0, n_noact = 0, g = 0;
    set_cfg(2, 3, 2, 1);
    tick(1, 0, 1, $urandom);
    do begin
      tick(0, 0, 1, $urandom);
      g++;
      checks++;
      if (obs !== exp_vec()) begin
        failures++; $display("FAIL act cyc=%0d got=%h exp=%h", g, obs, exp_vec());
      end
      n_act += (pe_state == K_ACT); n_done += done; n_noact += (do_act == 1'b0);
    end while (m_q.size() > 0 && g < 500);
    checks++; if (g >= 500) begin failures++; $display("FAIL act_timeout cycles=%0d limit=500", g); end
    checks++; if (n_act != 2 * ACTN) begin failures++; $display("FAIL act_len got=%0d exp=%0d", n_act, 2 * ACTN); end
    checks++; if (n_done != 1) begin failures++; $display("FAIL act_done got=%0d exp=1", n_done); end
    checks++; if (n_noact != 0) begin failures++; $display("FAIL act_doact_low got=%0d exp=0", n_noact); end
  endtask

  task automatic test_stall();
    logic [31:0] ma[$];
    bit          vs[6]  = '{1, 1, 0, 0, 1, 1};
    logic [31:0] ds[6]  = '{32'h3f80_0000, 32'h4580_0000, 32'h1111_1111,
                            32'h2222_2222, 32'h4000_0000, 32'h4040_0000};
    int bubbles = 0, g = 0;
    bit in_ma = 0;
    set_cfg(1, 2, 1, 0);
    tick(1, 0, 0, 32'h0);
    do begin
      if (g < 6) tick(0, 0, vs[g], ds[g]);
      else       tick(0, 0, 0, $urandom);
      g++;
      checks++;
      if (obs !== exp_vec()) begin
        failures++; $display("FAIL stall cyc=%0d got=%h exp=%h", g, obs, exp_vec());
      end
      if (pe_state == K_MA) begin ma.push_back(pe_data); in_ma = 1; end
      else if (pe_state == K_BIAS) in_ma = 0;
      else if (in_ma && pe_state == K_IDLE) bubbles++;
    end while (m_q.size() > 0 && g < 300);
    checks++; if (g >= 300) begin failures++; $display("FAIL stall_timeout cycles=%0d limit=300", g); end
    checks++; if (bubbles != 2) begin failures++; $display("FAIL stall_bubbles got=%0d exp=2", bubbles); end
    checks++;
    if (ma.size() != 2 || ma[0] !== 32'h4580_0000 || ma[1] !== 32'h4000_0000) begin
      failures++; $display("FAIL stall_ma_words got_n=%0d exp=45800000,40000000", ma.size());
    end
  endtask

  task automatic test_abort();
    int g = 0, in_act = 0, n_done = 0;
    set_cfg(2, 1, 1, 1);
    tick(1, 0, 1, $urandom);
    while (in_act < 5 && g < 200) begin
      tick(0, 0, 1, $urandom);
      g++;
      checks++;
      if (obs !== exp_vec()) begin
        failures++; $display("FAIL abort_pre cyc=%0d got=%h exp=%h", g, obs, exp_vec());
      end
      in_act += (pe_state == K_ACT);
    end
    checks++; if (g >= 200) begin failures++; $display("FAIL abort_reach_act cycles=%0d limit=200", g); end
    tick(1, 1, 1, $urandom);
    checks++;
    if (obs !== 40'h0) begin failures++; $display("FAIL abort_outputs got=%h exp=%h", obs, 40'h0); end
    for (int i = 0; i < 30; i++) begin
      tick(0, 0, 1, $urandom);
      n_done += done;
    end
    checks++; if (n_done != 0) begin failures++; $display("FAIL abort_no_done got=%0d exp=0", n_done); end
    set_cfg(3, 2, 1, 0);
    tick(1, 0, 1, $urandom);
    g = 0;
    do begin
      tick(0, 0, 1, $urandom);
      g++;
      checks++;
      if (obs !== exp_vec()) begin
        failures++; $display("FAIL abort_restart cyc=%0d got=%h exp=%h", g, obs, exp_vec());
      end
      n_done += done;
    end while (m_q.size() > 0 && g < 300);
    checks++; if (n_done != 1) begin failures++; $display("FAIL abort_restart_done got=%0d exp=1", n_done); end
  endtask

  task automatic test_reset_mid();
    int n_done = 0;
    set_cfg(10, 2, 1, 1);
    tick(1, 0, 1, $urandom);
    for (int i = 0; i < 3; i++) tick(0, 0, 1, $urandom);
    set_cfg(0, 1, 1, 0);
    tick(1, 0, 1, $urandom);
    checks++;
    if (obs !== exp_vec()) begin
      failures++; $display("FAIL busy_start_ignored got=%h exp=%h", obs, exp_vec());
    end
    in_valid = 1'b1;
    #2 rst = 1'b0;
    #1;
    model_reset();
    checks++;
    if (obs !== 40'h0) begin failures++; $display("FAIL async_reset got=%h exp=%h", obs, 40'h0); end
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick(0, 0, 1, $urandom);
      n_done += done;
    end
    checks++; if (n_done != 0) begin failures++; $display("FAIL reset_no_done got=%0d exp=0", n_done); end
    checks++;
    if (obs !== exp_vec()) begin failures++; $display("FAIL reset_post got=%h exp=%h", obs, exp_vec()); end
  endtask

  task automatic test_back_to_back();
    int n_done = 0, g = 0;
    for (int j = 0; j < 2; j++) begin
      set_cfg(j, 1 + j, 1, 0);
      tick(1, 0, 1, $urandom);
      g = 0;
      do begin
        tick(0, 0, 1, $urandom);
        g++;
        checks++;
        if (obs !== exp_vec()) begin
          failures++; $display("FAIL b2b job=%0d cyc=%0d got=%h exp=%h", j, g, obs, exp_vec());
        end
        n_done += done;
      end while (m_q.size() > 0 && g < 300);
    end
    checks++; if (n_done != 2) begin failures++; $display("FAIL b2b_done got=%0d exp=2", n_done); end
  endtask

  task automatic test_random();
    int g;
    for (int j = 0; j < 12; j++) begin
      set_cfg($urandom_range(0, 8), $urandom_range(1, 4), $urandom_range(1, 3), 1'($urandom_range(0, 1)));
      tick(1, 0, 1'($urandom_range(0, 1)), $urandom);
      g = 0;
      while (m_q.size() > 0 && g < 3000) begin
        if ($urandom_range(0, 7) == 0)
          set_cfg($urandom_range(0, 8), $urandom_range(1, 4), $urandom_range(1, 3), 1'($urandom_range(0, 1)));
        tick($urandom_range(0, 15) == 0, $urandom_range(0, 199) == 0,
             $urandom_range(0, 9) < 7, $urandom);
        g++;
        checks++;
        if (obs !== exp_vec()) begin
          failures++; $display("FAIL random job=%0d cyc=%0d got=%h exp=%h", j, g, obs, exp_vec());
        end
      end
      checks++; if (g >= 3000) begin failures++; $display("FAIL random_timeout job=%0d limit=3000", j); end
      repeat ($urandom_range(0, 2)) begin
        tick(0, 0, 1'($urandom_range(0, 1)), $urandom);
        checks++;
        if (obs !== exp_vec()) begin
          failures++; $display("FAIL random_gap job=%0d got=%h exp=%h", j, obs, exp_vec());
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_act_multipass();
    test_stall();
    test_abort();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog time=%0t limit=500000", $time);
    $fatal(1, "watchdog expired");
  end

endmodule : tb_pe_sequencer
`default_nettype wire
